// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared light/state types and default dwell constants for the crossing controller
package sig_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  localparam int Y2R_DELAY_DEF = 3;
  localparam int R2G_DELAY_DEF = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sig_control_if.sv
// rtl/sig_control_if.sv - car sensor in, highway/country lights out
interface sig_control_if;
  import sig_pkg::*;

  logic   x;
  light_t highway;
  light_t country;

  modport master (
    output x,
    input  highway,
    input  country
  );

  modport slave (
    input  x,
    output highway,
    output country
  );

endinterface

// File: rtl/sig_timer.sv
// rtl/sig_timer.sv - loadable dwell down-counter with zero flag
module sig_timer #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so untimed states leave it parked there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sig_control.sv
// rtl/sig_control.sv - highway/country crossing FSM with timed yellow and all-red phases
module sig_control
  import sig_pkg::*;
#(
  parameter int Y2R_DELAY = Y2R_DELAY_DEF,
  parameter int R2G_DELAY = R2G_DELAY_DEF
) (
  input  logic          clock,
  input  logic          clear,
  sig_control_if.slave  bus
);

  localparam int CW = $clog2(max2(Y2R_DELAY, R2G_DELAY)) + 1;
  localparam logic [CW-1:0] Y2R_LOAD = CW'(Y2R_DELAY - 1);
  localparam logic [CW-1:0] R2G_LOAD = CW'(R2G_DELAY - 1);

  state_t          state_q, state_d;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            dwell_done;

  sig_timer #(.W(CW)) u_timer (
    .clock      (clock),
    .clear      (clear),
    .load_i     (load),
    .load_val_i (load_val),
    .zero_o     (dwell_done)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // The timer is loaded on the edge that enters a timed state, so it reads
  // delay-1 during the first cycle of that state.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      S0: begin
        if (bus.x) begin
          state_d  = S1;
          load     = 1'b1;
          load_val = Y2R_LOAD;
        end
      end
      S1: begin
        if (dwell_done) begin
          state_d  = S2;
          load     = 1'b1;
          load_val = R2G_LOAD;
        end
      end
      S2: begin
        if (dwell_done) begin
          state_d = S3;
        end
      end
      S3: begin
        if (!bus.x) begin
          state_d  = S4;
          load     = 1'b1;
          load_val = Y2R_LOAD;
        end
      end
      S4: begin
        if (dwell_done) begin
          state_d = S0;
        end
      end
      default: state_d = S0;
    endcase
  end

  always_comb begin
    bus.highway = GREEN;
    bus.country = RED;
    case (state_q)
      S1: begin
        bus.highway = YELLOW;
        bus.country = RED;
      end
      S2: begin
        bus.highway = RED;
        bus.country = RED;
      end
      S3: begin
        bus.highway = RED;
        bus.country = GREEN;
      end
      S4: begin
        bus.highway = RED;
        bus.country = YELLOW;
      end
      default: begin
        bus.highway = GREEN;
        bus.country = RED;
      end
    endcase
  end

endmodule

// File: tb/tb_sig_control.sv
// tb/tb_sig_control.sv - bench for sig_control, default delays and a 1/4 delay variant
module tb_sig_control;
  import sig_pkg::*;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference: phase 0..4 of the crossing plus cycles spent in the phase.
  int ph [2];
  int el [2];

  always #5 clock = ~clock;

  sig_control_if bus_a ();
  sig_control_if bus_b ();

  sig_control dut_a (
    .clock (clock),
    .clear (clear),
    .bus   (bus_a.slave)
  );

  sig_control #(.Y2R_DELAY(1), .R2G_DELAY(4)) dut_b (
    .clock (clock),
    .clear (clear),
    .bus   (bus_b.slave)
  );

  function automatic int dur(input int k, input int p);
    if (p == 2) return (k == 0) ? 2 : 4;
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic [1:0] exp_hw(input int p);
    case (p)
      0:       return 2'd2;
      1:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_ct(input int p);
    case (p)
      3:       return 2'd2;
      4:       return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0;
      el[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic xv);
    case (ph[k])
      0: if (xv) begin ph[k] = 1; el[k] = 0; end
      3: if (!xv) begin ph[k] = 4; el[k] = 0; end
      default: begin
        el[k] = el[k] + 1;
        if (el[k] == dur(k, ph[k])) begin
          ph[k] = (ph[k] == 4) ? 0 : ph[k] + 1;
          el[k] = 0;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, expv, cyc);
    end
  endtask

  task automatic check_outputs();
    chk("a_highway", bus_a.highway, exp_hw(ph[0]));
    chk("a_country", bus_a.country, exp_ct(ph[0]));
    chk("b_highway", bus_b.highway, exp_hw(ph[1]));
    chk("b_country", bus_b.country, exp_ct(ph[1]));
    chk("a_safety", {1'b0, (bus_a.highway != RED) && (bus_a.country != RED)}, 2'd0);
    chk("b_safety", {1'b0, (bus_b.highway != RED) && (bus_b.country != RED)}, 2'd0);
  endtask

  // One clock: check at the falling edge, drive, then advance the model at the rising edge.
  task automatic cycle(input logic xa, input logic clr);
    logic xb;
    @(negedge clock);
    check_outputs();
    xb = ((cyc % 30) < 20);
    bus_a.x = xa;
    bus_b.x = xb;
    clear = clr;
    @(posedge clock);
    cyc++;
    if (clear) begin
      model_step(0, xa);
      model_step(1, xb);
    end else begin
      reset_model();
    end
  endtask

  initial begin
    int   len;
    logic val;
    bus_a.x = 1'b0;
    bus_b.x = 1'b0;
    reset_model();

    repeat (5) cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);

    repeat (10) cycle(1'b1, 1'b1);
    repeat (8) cycle(1'b0, 1'b1);

    cycle(1'b1, 1'b1);
    repeat (12) cycle(1'b0, 1'b1);

    repeat (6) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1);

    cycle(1'b1, 1'b1);
    for (int i = 0; i < 10 && ph[0] != 2; i++) cycle(1'b0, 1'b1);
    @(negedge clock);
    chk("pre_clear_hw", bus_a.highway, 2'd0);
    chk("pre_clear_ct", bus_a.country, 2'd0);
    #2 clear = 1'b0;
    #1;
    chk("async_a_hw", bus_a.highway, 2'd2);
    chk("async_a_ct", bus_a.country, 2'd0);
    chk("async_b_hw", bus_b.highway, 2'd2);
    chk("async_b_ct", bus_b.country, 2'd0);
    reset_model();
    repeat (2) cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b1);

    repeat (40) cycle(1'b1, 1'b1);
    repeat (6) cycle(1'b0, 1'b1);

    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 8);
      val = 1'($urandom_range(0, 1));
      repeat (len) cycle(val, 1'b1);
    end
    repeat (4) cycle(1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_control.md
Name: sig_control

Overview:
- Traffic-signal controller for a highway / country-road crossing.
- Highway stays green by default. When the car sensor `x` is asserted, the controller sequences highway through yellow and all-red, then gives the country road green for as long as `x` remains high. It then returns via country yellow to highway green.
- Moore FSM with a programmable dwell timer; single clock domain; sits directly behind the road-sensor input.

Parameters:
- Y2R_DELAY, 3, number of clock cycles a yellow phase lasts (S1 and S4); must be >= 1.
- R2G_DELAY, 2, number of clock cycles of the all-red phase (S2); must be >= 1.

Ports:
- clock  input  1  system clock; all state changes occur on the rising edge.
- clear  input  1  reset; asynchronous, active-low.
- x  input  1  car present on country road (1 = car waiting); synchronous to clock.
- highway  output  2  highway light: 2'd0 RED, 2'd1 YELLOW, 2'd2 GREEN.
- country  output  2  country light, same encoding.

Behaviour:
- Light encoding: RED=0, YELLOW=1, GREEN=2. The value 3 is never driven.
- States and outputs (highway/country):
  - S0: GREEN/RED
  - S1: YELLOW/RED
  - S2: RED/RED
  - S3: RED/GREEN
  - S4: RED/YELLOW
- Outputs are a pure combinational decode of the state register. No output depends directly on `x`.
- Reset:
  - clear=0 immediately forces state S0 and clears the dwell counter, asynchronously.
  - Outputs during and after reset: highway=2, country=0.
  - Reset asserted mid-sequence aborts the sequence with no intermediate states.
  - Release is recognised at the next rising edge.
- Transitions, evaluated at each rising edge:
  - S0: if x=1, go to S1; else stay in S0.
  - S1: dwell exactly Y2R_DELAY cycles, then go to S2. `x` is ignored.
  - S2: dwell exactly R2G_DELAY cycles, then go to S3. `x` is ignored.
  - S3: if x=0, go to S4; else stay in S3. Minimum occupancy is 1 cycle.
  - S4: dwell exactly Y2R_DELAY cycles, then go to S0. `x` is ignored.
- Dwell counter:
  - Loaded with (delay-1) on entry to a timed state.
  - Decrements each cycle; the state exits on the edge where the counter equals 0.
  - Counter width is $clog2(max(Y2R_DELAY,R2G_DELAY))+1.
- Boundary cases:
  - x dropping during S1/S2: the sequence still reaches S3, then leaves after one cycle.
  - x rising during S4: S4 completes to S0, then goes to S1 on the next edge where x=1.
  - x held high permanently: the controller stays in S3 indefinitely.
  - Illegal state encodings recover to S0 on the next edge.
- Safety invariant: highway and country are never both non-RED in the same cycle.

Decomposition:
- Shared package sig_pkg:
  - light_t enum: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
  - state_t enum: S0..S4, 3-bit.
  - Default delay constants Y2R_DELAY_DEF=3 and R2G_DELAY_DEF=2.
- One natural sub-module, sig_timer: a loadable down-counter with load value, load strobe and zero flag. It is instantiated once.
- The FSM and output decode stay in sig_control.

Test Plan:
- Reset/idle: clock period 10; clear=0 for 5 cycles, then 1; x=0 for 20 cycles -> highway=2, country=0 throughout. Verify clear=0 forces 2/0 asynchronously.
- Full cycle, default delays: x=1 sampled at edge N -> highway=1 for cycles N..N+2. Then 0/0 for N+3..N+4. Then country=2 from N+5 while x=1.
- Country release: in S3, x=0 sampled at edge M -> country=1 for 3 cycles, then highway=2/country=0, held while x=0.
- Short pulse: x=1 for one cycle only in S0 -> the full S1(3)->S2(2) sequence runs, then S3 for 1 cycle, S4 for 3 cycles, back to S0.
- Reset mid-sequence: assert clear during S2 (0/0) -> outputs immediately become 2/0. After release with x=0, the controller stays in S0.
- Parameter sweep (Y2R_DELAY=1, R2G_DELAY=4) with repeated 20/10-cycle x pulses -> dwell lengths match the parameters. Assert every cycle that highway and country are never both non-RED.
